// File: rtl/uart_pkg.sv
// Shared types for uart_fifo_ctrl: FSM state encodings and the default data width.
package uart_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    WR_IDLE  = 1'b0,
    WR_PULSE = 1'b1
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_POP  = 2'd1,
    RD_CAP  = 2'd2,
    RD_HOLD = 2'd3
  } rd_state_e;

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin arbiter. Grant is combinational from the requests;
// priority flips to the other requester whenever upd_i reports a taken grant.
module uart_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  logic prio_b_q;  // 0: requester 0 (A) wins a tie, 1: requester 1 (B) wins

  // Lone requester always wins; a tie is broken by the priority flag.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) gnt_o = prio_b_q ? 2'b10 : 2'b01;
  end

  // After serving A, hand priority to B, and vice versa.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        prio_b_q <= 1'b0;
    else if (upd_i) prio_b_q <= gnt_o[0];
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Two-requester write arbiter and single-consumer reader around a normal-mode
// FIFO. The write and read FSMs are independent.
// Optional: define UART_FIFO_CTRL_STATS_EN to add wr_count/rd_count counters.
module uart_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_valid,
  output logic              b_ready,
  output logic [DATA_W-1:0] fifo_data,
  output logic              fifo_wrreq,
  input  logic              fifo_wrfull,
  output logic              fifo_rdreq,
  input  logic [DATA_W-1:0] fifo_q,
  input  logic              fifo_rdempty,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef UART_FIFO_CTRL_STATS_EN
  ,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
`endif
);

  wr_state_e         wr_state_q, wr_state_d;
  logic [DATA_W-1:0] fifo_data_q, fifo_data_d;
  logic              wrreq_q, wrreq_d;
  logic [1:0]        arb_req, gnt;
  logic              accept;

  rd_state_e         rd_state_q, rd_state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              rdreq_q, rdreq_d;

  // Requests reach the arbiter only when a write can be taken this cycle,
  // so a grant is the same thing as an accepted transfer.
  assign arb_req = (!rst && wr_state_q == WR_IDLE && !fifo_wrfull) ? {b_valid, a_valid} : 2'b00;
  assign accept  = |gnt;

  uart_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (arb_req),
    .upd_i (accept),
    .gnt_o (gnt)
  );

  assign a_ready    = gnt[0];
  assign b_ready    = gnt[1];
  assign fifo_data  = fifo_data_q;
  assign fifo_wrreq = wrreq_q;
  assign fifo_rdreq = rdreq_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;

  // Write FSM next state: latch the winner's byte, then a one-cycle wrreq pulse.
  always_comb begin
    wr_state_d  = wr_state_q;
    fifo_data_d = fifo_data_q;
    wrreq_d     = 1'b0;
    case (wr_state_q)
      WR_IDLE: if (accept) begin
        wr_state_d  = WR_PULSE;
        wrreq_d     = 1'b1;
        fifo_data_d = gnt[1] ? b_data : a_data;
      end
      WR_PULSE: wr_state_d = WR_IDLE;
      default:  wr_state_d = WR_IDLE;
    endcase
  end

  // Write FSM registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q  <= WR_IDLE;
      fifo_data_q <= '0;
      wrreq_q     <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      fifo_data_q <= fifo_data_d;
      wrreq_q     <= wrreq_d;
    end
  end

  // Read FSM next state: pop, wait for q, capture, hold until the consumer takes it.
  always_comb begin
    rd_state_d  = rd_state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    rdreq_d     = 1'b0;
    case (rd_state_q)
      RD_IDLE: if (!fifo_rdempty) begin
        rd_state_d = RD_POP;
        rdreq_d    = 1'b1;
      end
      RD_POP: rd_state_d = RD_CAP;
      RD_CAP: begin
        out_data_d  = fifo_q;
        out_valid_d = 1'b1;
        rd_state_d  = RD_HOLD;
      end
      RD_HOLD: if (out_ready) begin
        out_valid_d = 1'b0;
        rd_state_d  = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Read FSM registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q  <= RD_IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      rdreq_q     <= 1'b0;
    end else begin
      rd_state_q  <= rd_state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      rdreq_q     <= rdreq_d;
    end
  end

`ifdef UART_FIFO_CTRL_STATS_EN
  logic [15:0] wr_cnt_q, rd_cnt_q;

  // Count FIFO write and pop cycles; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_q + {15'd0, wrreq_q};
      rd_cnt_q <= rd_cnt_q + {15'd0, rdreq_q};
    end
  end

  assign wr_count = wr_cnt_q;
  assign rd_count = rd_cnt_q;
`else
  // Statistics counters compiled out.
`endif

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Scoreboard bench for uart_fifo_ctrl with a behavioural normal-mode FIFO.
module tb_uart_fifo_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic          a_ready, b_ready;
  logic [DW-1:0] fifo_data;
  logic          fifo_wrreq;
  logic          fifo_wrfull = 1'b0;
  logic          fifo_rdreq;
  logic [DW-1:0] fifo_q = '0;
  logic          fifo_rdempty;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
`ifdef UART_FIFO_CTRL_STATS_EN
  logic [15:0]   wr_count, rd_count;
`endif

  int checks = 0;
  int errors = 0;

  logic          hold_empty = 1'b1;
  int            fcnt = 0;
  logic [DW-1:0] mem[$];
  logic [DW-1:0] exp_wr[$];
  logic [DW-1:0] exp_out[$];

  uart_fifo_ctrl #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq), .fifo_wrfull(fifo_wrfull),
    .fifo_rdreq(fifo_rdreq), .fifo_q(fifo_q), .fifo_rdempty(fifo_rdempty),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef UART_FIFO_CTRL_STATS_EN
    , .wr_count(wr_count), .rd_count(rd_count)
`endif
  );

  always #5 clk = ~clk;

  assign fifo_rdempty = hold_empty || (fcnt == 0);

  // Behavioural FIFO: q appears one cycle after rdreq.
  always @(posedge clk) begin
    int n;
    n = fcnt;
    if (fifo_rdreq) begin
      checks++;
      if (n == 0) begin
        errors++;
        $display("FAIL rdreq_on_empty got rdreq=1 want rdreq=0 while empty");
      end else begin
        fifo_q <= mem.pop_front();
        n--;
      end
    end
    if (fifo_wrreq) begin
      mem.push_back(fifo_data);
      n++;
    end
    fcnt <= n;
  end

  // Write-port monitor.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (!rst && fifo_wrreq) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got %h want no write", fifo_data);
      end else begin
        e = exp_wr.pop_front();
        if (fifo_data !== e) begin
          errors++;
          $display("FAIL wr_data got %h want %h", fifo_data, e);
        end
      end
    end
  end

  // Consumer monitor: data order and stability under back-pressure.
  logic          stall_q = 1'b0;
  logic [DW-1:0] held = '0;
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (out_valid && stall_q) begin
        checks++;
        if (out_data !== held) begin
          errors++;
          $display("FAIL out_stable got %h want %h", out_data, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_out.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected got %h want no transfer", out_data);
        end else begin
          e = exp_out.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL out_data got %h want %h", out_data, e);
          end
        end
      end
      stall_q = out_valid && !out_ready;
      held    = out_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_byte(input logic [DW-1:0] d);
    exp_wr.push_back(d);
    exp_out.push_back(d);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while ((exp_out.size() != 0 || exp_wr.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    chk("drain_timeout", {31'd0, exp_out.size() != 0 || exp_wr.size() != 0}, 32'd0);
  endtask

  task automatic lone_write(input bit use_b, input logic [DW-1:0] d);
    if (use_b) begin b_data = d; b_valid = 1'b1; end
    else       begin a_data = d; a_valid = 1'b1; end
    expect_byte(d);
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    // Reset state, with requests present during reset.
    a_valid = 1'b1;
    b_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_wrreq", fifo_wrreq, 0);
    chk("rst_rdreq", fifo_rdreq, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fifo_data", fifo_data, 0);
    chk("rst_out_data", out_data, 0);
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Single A write 0x41: ready now, wrreq with data on the next cycle only.
    a_data = 8'h41; a_valid = 1'b1;
    #1;
    chk("t1_a_ready", a_ready, 1);
    chk("t1_b_ready", b_ready, 0);
    chk("t1_wrreq_pre", fifo_wrreq, 0);
    expect_byte(8'h41);
    tick();
    a_valid = 1'b0;
    chk("t1_wrreq", fifo_wrreq, 1);
    chk("t1_fifo_data", fifo_data, 8'h41);
    chk("t1_a_ready_pulse", a_ready, 0);
    tick();
    chk("t1_wrreq_off", fifo_wrreq, 0);

    // Priority is now B, but a lone A still wins; then a lone B.
    a_data = 8'h42; a_valid = 1'b1;
    #1;
    chk("lone_a_ready", a_ready, 1);
    expect_byte(8'h42);
    tick();
    a_valid = 1'b0;
    tick();
    b_data = 8'h33; b_valid = 1'b1;
    #1;
    chk("lone_b_ready", b_ready, 1);
    chk("lone_b_a_ready", a_ready, 0);
    expect_byte(8'h33);
    tick();
    b_valid = 1'b0;
    tick();

    // Both valid: alternating writes, one every two cycles, A first.
    a_data = 8'h10; b_data = 8'h20;
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    chk("rr_first_a", a_ready, 1);
    chk("rr_first_b", b_ready, 0);
    expect_byte(8'h10); expect_byte(8'h20);
    expect_byte(8'h10); expect_byte(8'h20);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("rr_wrreq_%0d", i), fifo_wrreq, (i % 2 == 1) ? 1 : 0);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick();

    // FIFO full blocks A until full drops.
    fifo_wrfull = 1'b1;
    a_data = 8'h77; a_valid = 1'b1;
    #1;
    chk("full_a_ready", a_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_a_ready_hold", a_ready, 0);
      chk("full_wrreq", fifo_wrreq, 0);
    end
    fifo_wrfull = 1'b0;
    #1;
    chk("unfull_a_ready", a_ready, 1);
    expect_byte(8'h77);
    tick();
    a_valid = 1'b0;
    chk("unfull_wrreq", fifo_wrreq, 1);
    tick();

    // Drain everything written so far in order.
    out_ready = 1'b1;
    hold_empty = 1'b0;
    wait_drain(200);
    hold_empty = 1'b1;
    out_ready = 1'b0;

    // Read path: 3-cycle latency, data held under back-pressure, single pop.
    lone_write(1'b0, 8'h55);
    lone_write(1'b1, 8'h66);
    hold_empty = 1'b0;
    tick();
    chk("rd_pop", fifo_rdreq, 1);
    chk("rd_pop_valid", out_valid, 0);
    tick();
    chk("rd_cap_rdreq", fifo_rdreq, 0);
    chk("rd_cap_valid", out_valid, 0);
    tick();
    chk("rd_valid", out_valid, 1);
    chk("rd_data", out_data, 8'h55);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rd_hold_rdreq", fifo_rdreq, 0);
      chk("rd_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    wait_drain(50);
    out_ready = 1'b0;
    hold_empty = 1'b1;

    // Asynchronous reset while WR_PULSE and RD_POP are both active.
    lone_write(1'b0, 8'hAA);
    a_data = 8'hBB; a_valid = 1'b1;
    hold_empty = 1'b0;
    tick();
    chk("pre_rst_wrreq", fifo_wrreq, 1);
    chk("pre_rst_rdreq", fifo_rdreq, 1);
    #1;
    rst = 1'b1;
    a_valid = 1'b0;
    hold_empty = 1'b1;
    #1;
    chk("arst_wrreq", fifo_wrreq, 0);
    chk("arst_rdreq", fifo_rdreq, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_fifo_data", fifo_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_data = 8'h5A; b_data = 8'hA5;
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    chk("post_rst_a_ready", a_ready, 1);
    chk("post_rst_b_ready", b_ready, 0);
    expect_byte(8'h5A);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    hold_empty = 1'b0;
    wait_drain(100);

`ifdef UART_FIFO_CTRL_STATS_EN
    // Since the last reset: one write (0x5A) and two pops (0xAA, 0x5A).
    hold_empty = 1'b1;
    chk("stats_wr1", wr_count, 1);
    chk("stats_rd2", rd_count, 2);
    lone_write(1'b0, 8'h01);
    lone_write(1'b1, 8'h02);
    chk("stats_wr3", wr_count, 3);
    chk("stats_rd_still2", rd_count, 2);
    force dut.wr_cnt_q = 16'hFFFF;
    #1;
    release dut.wr_cnt_q;
    lone_write(1'b0, 8'h03);
    chk("stats_wrap", wr_count, 0);
    hold_empty = 1'b0;
    wait_drain(100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_fifo_ctrl.md
UART_FIFO_CTRL -- requirements
Module: uart_fifo_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, width of requester, FIFO and consumer data paths.
REQ-002 clk  in  1  single clock for all logic, including the FIFO rdclk and wrclk.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 a_data/a_valid/a_ready  in/in/out  DATA_W/1/1  requester A write channel.
REQ-005 b_data/b_valid/b_ready  in/in/out  DATA_W/1/1  requester B write channel.
REQ-006 fifo_data/fifo_wrreq/fifo_wrfull  out/out/in  DATA_W/1/1  FIFO write port.
REQ-007 fifo_rdreq/fifo_q/fifo_rdempty  out/in/in  1/DATA_W/1  FIFO read port; normal mode, q valid one cycle after rdreq.
REQ-008 out_data/out_valid/out_ready  out/out/in  DATA_W/1/1  consumer channel.

Function
REQ-009 Write FSM SHALL have states WR_IDLE and WR_PULSE.
REQ-010 In WR_IDLE with fifo_wrfull=0, a_ready/b_ready SHALL be combinational and asserted only for the arbitration winner among valid requesters; with fifo_wrfull=1 or in WR_PULSE both SHALL be 0.
REQ-011 A transfer is accepted on valid&&ready; that edge SHALL latch the data into fifo_data and enter WR_PULSE.
REQ-012 fifo_wrreq SHALL be a register equal to 1 exactly during WR_PULSE; WR_PULSE SHALL return to WR_IDLE unconditionally, giving at most one write every 2 cycles.
REQ-013 Arbitration SHALL be round-robin: after a grant to A, B has priority, and vice versa; a lone valid requester SHALL win regardless of priority.
REQ-014 Read FSM SHALL have states RD_IDLE, RD_POP, RD_CAP and RD_HOLD.
REQ-015 RD_IDLE SHALL go to RD_POP when fifo_rdempty=0.
REQ-016 RD_POP SHALL go to RD_CAP unconditionally.
REQ-017 RD_CAP SHALL load out_data from fifo_q, set out_valid and go to RD_HOLD.
REQ-018 RD_HOLD SHALL go to RD_IDLE on out_valid&&out_ready, clearing out_valid on the same edge.
REQ-019 fifo_rdreq SHALL be a register equal to 1 exactly during RD_POP, so one pop occurs per consumer transfer.
REQ-020 Latency from fifo_rdempty falling in RD_IDLE to out_valid high SHALL be 3 cycles.
REQ-021 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 Write and read FSMs SHALL be independent, so simultaneous write and pop are permitted.
REQ-023 fifo_wrreq SHALL never assert while fifo_wrfull was 1 at the accepting edge, and fifo_rdreq SHALL never assert while fifo_rdempty was 1 at the deciding edge.

Reset
REQ-024 On rst both FSMs SHALL enter IDLE immediately (asynchronous reset), independent of clk.
REQ-025 On rst fifo_wrreq, fifo_rdreq, out_valid and the ready outputs SHALL be 0.
REQ-026 On rst fifo_data and out_data SHALL be 0, and round-robin priority SHALL go to A.
REQ-027 Reset mid-transfer SHALL discard any latched or in-flight byte without a retry.

Configuration
REQ-028 With UART_FIFO_CTRL_STATS_EN defined, outputs wr_count[15:0] and rd_count[15:0] SHALL exist, reset to 0, increment on each fifo_wrreq and fifo_rdreq cycle respectively, and wrap from 0xFFFF to 0.
REQ-029 Without UART_FIFO_CTRL_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 Package uart_pkg SHALL hold the write-state and read-state encodings and the DATA_W default.
REQ-031 Round-robin grant logic SHALL be a sub-module uart_rr_arb2 (inputs: two requests, priority-update strobe; outputs: one-hot grant).

Verification
REQ-032 Sequence: a_valid only, a_data=0x41, FIFO not full -> a_ready=1 in one cycle; fifo_wrreq=1 with fifo_data=0x41 on the next cycle only.
REQ-033 Sequence: a and b valid continuously, data 0x10 and 0x20 -> writes alternate 0x10, 0x20, 0x10, 0x20 at one every 2 cycles.
REQ-034 Sequence: fifo_wrfull=1 with a_valid=1 -> a_ready=0 and fifo_wrreq=0 until wrfull falls; then the write occurs.
REQ-035 Sequence: FIFO holds 0x55, out_ready=0 -> fifo_rdreq pulses once, out_valid=1 three cycles later, out_data=0x55 held; no further rdreq until out_ready=1.
REQ-036 Sequence: rst asserted during RD_POP and WR_PULSE -> rdreq and wrreq fall without a clk edge, out_valid=0, and the next grant goes to A.
REQ-037 Sequence (STATS_EN): 3 writes and 2 reads -> wr_count=3 and rd_count=2; with the counter preset near 0xFFFF, wrap to 0 is checked.
